uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL: parameter CLK_FREQ, 50_000_000, system clock frequency in Hz.
REQ-002 SHALL: parameter BAUD, 9600, line bit rate.
REQ-003 SHALL: clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL: rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL: rx_data  output  8  last correctly received byte, held until next good frame; drives the 7-segment decoder's ASCII input.
REQ-007 SHALL: rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-008 SHALL: frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL: rx_busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL: synchronise rx through two flip-flops; all decisions use the synchronised value only.
REQ-011 SHALL: generate an oversample tick every DIV = CLK_FREQ/(BAUD*16) clocks (integer division), one cycle wide; divider held at 0 while in IDLE and restarted on start-edge detection.
REQ-012 SHALL: implement states IDLE, START, DATA, STOP.
REQ-013 SHALL: IDLE -> START on a synchronised 1->0 transition only; a line held low does not retrigger.
REQ-014 SHALL: START: after 8 ticks, sample the line; 0 -> DATA, 1 -> IDLE (glitch rejected, no output pulse).
REQ-015 SHALL: DATA: sample every 16 ticks, shift in LSB first; after the 8th sample -> STOP.
REQ-016 SHALL: STOP: after 16 ticks, sample the line; 1 -> load rx_data from the shift register and pulse rx_valid; 0 -> pulse frame_err, leave rx_data unchanged; both -> IDLE.
REQ-017 SHALL: rx_valid/frame_err assert in the clock cycle after the stop-bit sample; never both in the same cycle.
REQ-018 SHALL: accept a new start edge in the first IDLE cycle after STOP (back-to-back frames, zero idle gap).
REQ-019 SHALL: keep the bit counter 3 bits and the tick counter 4 bits, wrapping naturally; no other counter exceeds clog2(DIV) bits.

Reset
REQ-020 SHALL: on rst, set state IDLE, counters 0, shift register 0, synchroniser flops 1.
REQ-021 SHALL: reset values rx_data = 8'h30 (ASCII '0', display shows "0"), rx_valid = 0, frame_err = 0, rx_busy = 0.
REQ-022 SHALL: rst asserted mid-frame abandons the frame with no rx_valid/frame_err pulse; rst has priority over every other event.

Structure
REQ-023 SHALL: shared package uart_pkg holds the state encoding, OVS = 16, data width 8, idle-line level, and the reset display code 8'h30.
REQ-024 SHALL: oversample tick generator is a separate sub-module, uart_baud_tick (ports clk, rst, clear, tick; parameter DIV).
REQ-025 SHALL: FSM, shift register and output registers live in uart_rx; no latches, all outputs registered.

Verification (CLK_FREQ=50_000_000, BAUD=115200 -> DIV=27, bit = 432 clk)
REQ-026 SHALL: after rst release, check rx_data=8'h30, rx_valid=0, frame_err=0, rx_busy=0.
REQ-027 SHALL: send 0x41 -> exactly one rx_valid pulse, rx_data=8'h41, frame_err never high.
REQ-028 SHALL: drive rx low for 81 clk (3 ticks) then high -> no rx_valid/frame_err; rx_busy falls within 8 ticks; rx_data unchanged.
REQ-029 SHALL: send 0x35 with stop bit 0 -> one frame_err pulse, rx_data stays 8'h41.
REQ-030 SHALL: send 0x30 then 0x39 back-to-back, no idle gap -> two rx_valid pulses, rx_data 8'h30 then 8'h39.
REQ-031 SHALL: assert rst during bit 4 of 0x55 -> no pulse, outputs at reset values; next frame 0x42 -> rx_data=8'h42, one rx_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, oversampling and frame constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int          OVS      = 16;      // oversample ticks per bit
    localparam int          DATA_W   = 8;       // payload bits per frame
    localparam logic        IDLE_LVL = 1'b1;    // line level when nothing is sent
    localparam logic [7:0]  RST_DISP = 8'h30;   // ASCII '0' so the display reads "0" after reset

    // Clocks per oversample tick, truncated; never below 1 so the divider always runs.
    function automatic int baud_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OVS);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks while not cleared.
// Latency: first tick DIV clocks after clear drops; tick is decoded from the counter register.
// Backpressure: none; clear holds the counter at zero.
module uart_baud_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Free-running modulo-DIV counter, parked at zero while cleared.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling; holds last good byte for the display decoder.
// Latency: rx_valid/frame_err pulse one clock after the mid-stop-bit sample.
// Backpressure: none; result pulses are single-cycle and rx_data holds until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int         DIV       = baud_div(CLK_FREQ, BAUD);
    localparam logic [3:0] TICK_LAST = 4'(OVS - 1);
    localparam logic [3:0] TICK_MID  = 4'(OVS / 2 - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_W - 1);

    uart_state_e       state_q, state_d;
    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    logic [3:0]        tick_cnt_q, tick_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              rx_busy_q;
    logic              tick;
    logic              div_clear;

    // Divider idles at zero so the first tick lands DIV clocks after the start edge.
    assign div_clear = (state_q == ST_IDLE);

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .tick  (tick)
    );

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= IDLE_LVL;
            rx_sync_q <= IDLE_LVL;
            rx_prev_q <= IDLE_LVL;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // State, counters, shift register and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= RST_DISP;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Next-state logic: start qualification at mid start bit, then one sample per 16 ticks.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                // Only a 1->0 transition starts a frame; a line stuck low does not.
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        // High at mid start bit means it was a glitch.
                        state_d    = rx_sync_q ? ST_IDLE : ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == TICK_LAST) begin
                        shift_d   = {rx_sync_q, shift_q[DATA_W-1:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_STOP;
                        end
                    end
                end
            end

            ST_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == TICK_LAST) begin
                        state_d = ST_IDLE;
                        if (rx_sync_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 50 MHz / 115200 baud (27 clocks per tick, 432 per bit).
// Latency: expected results are due near the middle of each stop bit.
// Backpressure: n/a.
module tb_uart_rx;

    localparam int BIT_CLK = 432;
    localparam int DUE_OFS = 9 * BIT_CLK + BIT_CLK / 2;  // mid stop bit, relative to start edge
    localparam int WIN     = 8;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         due;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         n_valid = 0;
    int         n_err   = 0;
    logic       run = 1'b0;
    logic       prev_pulse = 1'b0;
    logic [7:0] model_data = 8'h30;
    ev_t        exp_q[$];
    logic [7:0] seen_q[$];

    uart_rx #(
        .CLK_FREQ (50_000_000),
        .BAUD     (115200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialise one 8N1 frame; the model expects a result near mid stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl);
        ev_t ev;
        rx = 1'b0;
        ev.is_err = !stop_lvl;
        ev.data   = b;
        ev.due    = cyc + DUE_OFS;
        exp_q.push_back(ev);
        hold(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(BIT_CLK);
        end
        rx = stop_lvl;
        hold(BIT_CLK);
        rx = 1'b1;
    endtask

    // Every cycle: compare pulses and held data against the frame-level model.
    always @(negedge clk) begin
        ev_t e;
        logic pulse;
        if (run && !rst) begin
            pulse = rx_valid | frame_err;
            chk("both_pulses", 32'(rx_valid & frame_err), 32'd0);
            chk("pulse_width", 32'(prev_pulse & pulse), 32'd0);
            if (pulse) begin
                chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pulse_kind_err", 32'(frame_err), 32'(e.is_err));
                    chk("pulse_time", 32'((cyc >= e.due - WIN) && (cyc <= e.due + WIN)), 32'd1);
                    if (!e.is_err) model_data = e.data;
                end
                if (rx_valid) begin
                    n_valid++;
                    seen_q.push_back(rx_data);
                end
                if (frame_err) n_err++;
            end
            chk("rx_data", 32'(rx_data), 32'(model_data));
            if (exp_q.size() != 0 && cyc > exp_q[0].due + WIN) begin
                total++;
                bad++;
                $display("FAIL missing_result: none by cycle %0d, due %0d", cyc, exp_q[0].due);
                void'(exp_q.pop_front());
            end
            prev_pulse = pulse;
        end else begin
            prev_pulse = 1'b0;
        end
    end

    initial begin
        int         waited;
        int         g;
        logic       ok;
        logic [7:0] b;

        rst = 1'b1;
        rx  = 1'b1;
        hold(3);
        rst = 1'b0;
        run = 1'b1;
        @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'h30);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        chk("reset_rx_busy", 32'(rx_busy), 32'd0);
        hold(20);

        // Good frame 'A'.
        send_frame(8'h41, 1'b1);
        hold(200);
        chk("A_data", 32'(rx_data), 32'h41);
        chk("A_valid_count", 32'(n_valid), 32'd1);
        chk("A_err_count", 32'(n_err), 32'd0);

        // Three-tick glitch is rejected at mid start bit.
        rx = 1'b0;
        hold(81);
        rx = 1'b1;
        chk("glitch_busy_high", 32'(rx_busy), 32'd1);
        waited = 81;
        while (rx_busy && waited < 8 * 27 + 14) begin
            hold(1);
            waited++;
        end
        chk("glitch_busy_fall", 32'(rx_busy), 32'd0);
        hold(100);
        chk("glitch_valid_count", 32'(n_valid), 32'd1);
        chk("glitch_err_count", 32'(n_err), 32'd0);
        chk("glitch_data", 32'(rx_data), 32'h41);

        // Bad stop bit.
        send_frame(8'h35, 1'b0);
        hold(200);
        chk("ferr_count", 32'(n_err), 32'd1);
        chk("ferr_valid_count", 32'(n_valid), 32'd1);
        chk("ferr_data_held", 32'(rx_data), 32'h41);

        // Back-to-back, zero idle gap.
        send_frame(8'h30, 1'b1);
        send_frame(8'h39, 1'b1);
        hold(200);
        chk("b2b_valid_count", 32'(n_valid), 32'd3);
        if (seen_q.size() >= 3) begin
            chk("b2b_first", 32'(seen_q[1]), 32'h30);
            chk("b2b_second", 32'(seen_q[2]), 32'h39);
        end else begin
            chk("b2b_seen", 32'(seen_q.size()), 32'd3);
        end
        chk("b2b_data", 32'(rx_data), 32'h39);

        // Reset in the middle of data bit 4 of 0x55.
        b  = 8'h55;
        rx = 1'b0;
        hold(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            hold(BIT_CLK);
        end
        rx = b[4];
        hold(BIT_CLK / 2);
        rst = 1'b1;
        model_data = 8'h30;
        exp_q.delete();
        hold(2);
        rx  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_data", 32'(rx_data), 32'h30);
        chk("rst_mid_valid", 32'(rx_valid), 32'd0);
        chk("rst_mid_ferr", 32'(frame_err), 32'd0);
        chk("rst_mid_busy", 32'(rx_busy), 32'd0);
        hold(BIT_CLK * 3);
        chk("rst_mid_no_pulse", 32'(n_valid + n_err), 32'd4);
        send_frame(8'h42, 1'b1);
        hold(200);
        chk("after_rst_data", 32'(rx_data), 32'h42);
        chk("after_rst_valid_count", 32'(n_valid), 32'd4);

        // Randomised frames, stop errors, gaps and glitches against the model.
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                rx = 1'b0;
                hold($urandom_range(10, 150));
                rx = 1'b1;
                hold(300);
            end
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok);
            if (!ok) g = $urandom_range(20, 300);
            else if ($urandom_range(0, 2) == 0) g = 0;
            else g = $urandom_range(1, 300);
            if (g > 0) hold(g);
        end
        hold(500);
        chk("all_results_seen", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
